countdown_timer: RTL

Countdown timer running on the 1 Hz clock, the decrementing counterpart of the 12-hour clock. It shares the clock's switch/debounced-button inputs and its hour/min/sec output format, so the same display path can show either block. The user enters a duration with the hour/min/sec buttons, starts the countdown with the start/stop switch, and the block counts down to 00:00:00. It then asserts `done` and blinks `alarm_out` until the mode switch is cleared.

---
 rtl/countdown_timer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Countdown timer on the 1 Hz clock: buttons preset hh:mm:ss, start_stop runs the count,
// and reaching 00:00:00 raises done and blinks alarm_out until mode_in is cleared.
module countdown_timer (
  input  logic       clk_1Hz,
  input  logic       resetn,
  input  logic       start_stop,
  input  logic       mode_in,
  input  logic       hour_in,
  input  logic       min_in,
  input  logic       sec_in,
  output logic [4:0] hour_out,
  output logic [5:0] min_out,
  output logic [5:0] sec_out,
  output logic       running,
  output logic       done,
  output logic       alarm_out
);

  localparam logic [1:0] StIdle      = 2'b00;
  localparam logic [1:0] StInput     = 2'b01;
  localparam logic [1:0] StCountdown = 2'b10;
  localparam logic [1:0] StDone      = 2'b11;

  logic [1:0] r_state;
  logic [4:0] r_hour;
  logic [5:0] r_min;
  logic [5:0] r_sec;
  logic       r_alarm;

  logic [1:0] w_state_d;
  logic [4:0] w_hour_d;
  logic [5:0] w_min_d;
  logic [5:0] w_sec_d;
  logic       w_alarm_d;
  logic       w_nonzero;
  logic       w_last_sec;

  assign w_nonzero  = |{r_hour, r_min, r_sec};
  assign w_last_sec = (r_hour == 5'd0) && (r_min == 6'd0) && (r_sec == 6'd1);

  always_comb begin
    w_state_d = r_state;
    w_hour_d  = r_hour;
    w_min_d   = r_min;
    w_sec_d   = r_sec;
    w_alarm_d = 1'b0;
    if (!mode_in) begin
      w_state_d = StIdle;
      w_hour_d  = 5'd0;
      w_min_d   = 6'd0;
      w_sec_d   = 6'd0;
    end else begin
      case (r_state)
        StIdle: begin
          w_hour_d = 5'd0;
          w_min_d  = 6'd0;
          w_sec_d  = 6'd0;
          if (!start_stop) w_state_d = StInput;
        end
        StInput: begin
          if (hour_in) w_hour_d = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
          if (min_in)  w_min_d  = (r_min  == 6'd59) ? 6'd0 : r_min  + 6'd1;
          if (sec_in)  w_sec_d  = (r_sec  == 6'd59) ? 6'd0 : r_sec  + 6'd1;
          // Start qualifies on the registered value, not the one being incremented.
          if (start_stop && w_nonzero) w_state_d = StCountdown;
        end
        StCountdown: begin
          // A zero value here only arises from a wrapping press on the entry edge.
          if (!w_nonzero) begin
            w_state_d = StDone;
            w_alarm_d = 1'b1;
          end else if (start_stop) begin
            if (r_sec != 6'd0) begin
              w_sec_d = r_sec - 6'd1;
            end else if (r_min != 6'd0) begin
              w_sec_d = 6'd59;
              w_min_d = r_min - 6'd1;
            end else begin
              w_sec_d  = 6'd59;
              w_min_d  = 6'd59;
              w_hour_d = r_hour - 5'd1;
            end
            if (w_last_sec) begin
              w_state_d = StDone;
              w_alarm_d = 1'b1;
            end
          end
        end
        StDone: begin
          w_hour_d  = 5'd0;
          w_min_d   = 6'd0;
          w_sec_d   = 6'd0;
          w_alarm_d = ~r_alarm;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_1Hz or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
      r_hour  <= 5'd0;
      r_min   <= 6'd0;
      r_sec   <= 6'd0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_hour  <= w_hour_d;
      r_min   <= w_min_d;
      r_sec   <= w_sec_d;
      r_alarm <= w_alarm_d;
    end
  end

  assign hour_out  = r_hour;
  assign min_out   = r_min;
  assign sec_out   = r_sec;
  assign running   = (r_state == StCountdown) && start_stop;
  assign done      = (r_state == StDone);
  assign alarm_out = r_alarm;

endmodule
